// File: rtl/control_unit_gen_if.sv
// control_unit_gen_if: bus between the fetch/execute sequencer and the
// IR/decoder, flag, memory-handshake and PC/AC/memory strobe logic.
//   master modport: sequencer side (decoder/flag/handshake in, strobes out)
//   slave  modport: datapath side (drives opcode, flags, mem_ready, irq)
//   opcode     IR upper word (OPW bits)
//   zflg/nflg  AC zero / negative flags
//   mem_ready  current fetch/read/store completes this cycle
//   irq        level interrupt request
//   state_o    current sequencer state encoding
//   fetch, ld_iru, ld_opnd, opnd_idx, incr_pc, mem_rd, ld_ac, ld_pc,
//   store_mem, irq_ack, halted   control strobes and status
interface control_unit_gen_if #(
    parameter int unsigned OPW = 8
);
    logic [OPW-1:0] opcode;
    logic           zflg;
    logic           nflg;
    logic           mem_ready;
    logic           irq;
    logic [3:0]     state_o;
    logic           fetch;
    logic           ld_iru;
    logic           ld_opnd;
    logic [1:0]     opnd_idx;
    logic           incr_pc;
    logic           mem_rd;
    logic           ld_ac;
    logic           ld_pc;
    logic           store_mem;
    logic           irq_ack;
    logic           halted;

    modport master (
        input  opcode, zflg, nflg, mem_ready, irq,
        output state_o, fetch, ld_iru, ld_opnd, opnd_idx, incr_pc,
               mem_rd, ld_ac, ld_pc, store_mem, irq_ack, halted
    );

    modport slave (
        output opcode, zflg, nflg, mem_ready, irq,
        input  state_o, fetch, ld_iru, ld_opnd, opnd_idx, incr_pc,
               mem_rd, ld_ac, ld_pc, store_mem, irq_ack, halted
    );
endinterface

// File: rtl/control_unit_gen.sv
// control_unit_gen: fetch/execute sequencer for the 8-bit accumulator core.
// Fetches the opcode word plus OPND_WORDS operand words, then reads the
// memory operand, executes, stores or jumps, with a memory ready/wait
// handshake, HALT and an instruction-boundary interrupt.
//   clk    rising-edge clock
//   reset  asynchronous, active-high; returns to START
//   bus    control_unit_gen_if.master (decoder/flags/handshake in, strobes out)
module control_unit_gen #(
    parameter int unsigned OPW        = 8,
    parameter int unsigned OPND_WORDS = 1,
    parameter bit          IRQ_EN     = 1'b1
) (
    input logic              clk,
    input logic              reset,
    control_unit_gen_if.master bus
);

    typedef enum logic [3:0] {
        ST_START  = 4'd0,
        ST_PREPU  = 4'd1,
        ST_FETCHU = 4'd2,
        ST_PREPL  = 4'd3,
        ST_FETCHL = 4'd4,
        ST_READ   = 4'd5,
        ST_EXEC   = 4'd6,
        ST_STORE  = 4'd7,
        ST_JUMP   = 4'd8,
        ST_IRQ    = 4'd9,
        ST_HALT   = 4'd10
    } state_t;

    localparam logic [OPW-1:0] OP_NOP   = OPW'(5'h00);
    localparam logic [OPW-1:0] OP_CLR   = OPW'(5'h04);
    localparam logic [OPW-1:0] OP_STORE = OPW'(5'h03);
    localparam logic [OPW-1:0] OP_JMP   = OPW'(5'h10);
    localparam logic [OPW-1:0] OP_JN    = OPW'(5'h11);
    localparam logic [OPW-1:0] OP_JNZ   = OPW'(5'h12);
    localparam logic [OPW-1:0] OP_JZ    = OPW'(5'h13);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(5'h1F);
    localparam logic [1:0]     LAST_IDX = 2'(OPND_WORDS - 1);

    state_t     state, state_next;
    logic [1:0] idx, idx_next;
    logic       irq_q;
    logic       class1, class2, is_cjump, jump_taken;
    state_t     boundary;

    assign irq_q    = IRQ_EN && bus.irq;
    assign boundary = irq_q ? ST_IRQ : ST_PREPU;

    assign class1   = (bus.opcode == OP_NOP) || (bus.opcode == OP_CLR);
    assign class2   = (bus.opcode == OPW'(5'h02)) || (bus.opcode == OPW'(5'h06)) ||
                      (bus.opcode == OPW'(5'h08)) || (bus.opcode == OPW'(5'h0E)) ||
                      (bus.opcode == OPW'(5'h0F));
    assign is_cjump = (bus.opcode == OP_JN) || (bus.opcode == OP_JNZ) ||
                      (bus.opcode == OP_JZ);
    assign jump_taken = ((bus.opcode == OP_JN)  &&  bus.nflg) ||
                        ((bus.opcode == OP_JNZ) && !bus.zflg) ||
                        ((bus.opcode == OP_JZ)  &&  bus.zflg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_START;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next    = state;
        idx_next      = idx;
        bus.fetch     = 1'b0;
        bus.ld_iru    = 1'b0;
        bus.ld_opnd   = 1'b0;
        bus.incr_pc   = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.ld_ac     = 1'b0;
        bus.ld_pc     = 1'b0;
        bus.store_mem = 1'b0;
        bus.irq_ack   = 1'b0;
        bus.halted    = 1'b0;
        case (state)
            ST_START: state_next = ST_PREPU;
            ST_PREPU: begin
                bus.fetch  = 1'b1;
                state_next = ST_FETCHU;
            end
            ST_FETCHU: begin
                bus.fetch = 1'b1;
                if (bus.mem_ready) begin
                    bus.ld_iru  = 1'b1;
                    bus.incr_pc = 1'b1;
                    idx_next    = '0;
                    state_next  = ST_PREPL;
                end
            end
            ST_PREPL: begin
                bus.fetch = 1'b1;
                if (class1)                     state_next = ST_EXEC;
                else if (bus.opcode == OP_HALT) state_next = ST_HALT;
                else                            state_next = ST_FETCHL;
            end
            ST_FETCHL: begin
                bus.fetch = 1'b1;
                if (bus.mem_ready) begin
                    bus.ld_opnd = 1'b1;
                    bus.incr_pc = 1'b1;
                    if (idx != LAST_IDX) begin
                        idx_next   = idx + 2'd1;
                        state_next = ST_PREPL;
                    end else begin
                        idx_next = '0;
                        // A not-taken conditional jump is itself an
                        // instruction boundary: no read, no exec.
                        if (class2)                         state_next = ST_EXEC;
                        else if (bus.opcode == OP_STORE)    state_next = ST_STORE;
                        else if (bus.opcode == OP_JMP)      state_next = ST_JUMP;
                        else if (is_cjump && jump_taken)    state_next = ST_JUMP;
                        else if (is_cjump)                  state_next = boundary;
                        else                                state_next = ST_READ;
                    end
                end
            end
            ST_READ: begin
                bus.mem_rd = 1'b1;
                if (bus.mem_ready) state_next = ST_EXEC;
            end
            ST_EXEC: begin
                bus.ld_ac  = 1'b1;
                state_next = boundary;
            end
            ST_STORE: begin
                bus.store_mem = 1'b1;
                if (bus.mem_ready) state_next = boundary;
            end
            ST_JUMP: begin
                bus.ld_pc  = 1'b1;
                state_next = boundary;
            end
            ST_IRQ: begin
                bus.irq_ack = 1'b1;
                bus.ld_pc   = 1'b1;
                state_next  = ST_PREPU;
            end
            ST_HALT: bus.halted = 1'b1;
            default: begin
                state_next = ST_START;
                idx_next   = '0;
            end
        endcase
    end

    assign bus.state_o  = state;
    assign bus.opnd_idx = idx;

endmodule

// File: tb/tb_control_unit_gen.sv
// tb_control_unit_gen: self-checking bench for control_unit_gen.
// Three instances (1 operand word, 3 operand words, interrupts disabled) are
// exercised one at a time while the others sit in reset. Each instruction
// is expanded by a reference model into a per-cycle list of expected state
// and strobes together with the inputs to drive that cycle.
module tb_control_unit_gen;

    typedef struct {
        logic [7:0]  op;
        logic        z;
        logic        n;
        logic        irq;
        logic        mr;
        logic [15:0] exp;
    } vec_t;

    localparam logic [11:0] F   = 12'h800;
    localparam logic [11:0] IRU = 12'h400;
    localparam logic [11:0] OPN = 12'h200;
    localparam logic [11:0] INC = 12'h040;
    localparam logic [11:0] RD  = 12'h020;
    localparam logic [11:0] AC  = 12'h010;
    localparam logic [11:0] PC  = 12'h008;
    localparam logic [11:0] ST  = 12'h004;
    localparam logic [11:0] ACK = 12'h002;
    localparam logic [11:0] HLT = 12'h001;

    logic       clk;
    logic [2:0] rst;
    logic [7:0] opcode;
    logic       zflg, nflg, mem_ready, irq;
    int         sel;
    logic [15:0] obs;
    int         vectors;
    int         miscompares;
    vec_t       q[$];

    control_unit_gen_if #(.OPW(8)) if_a ();
    control_unit_gen_if #(.OPW(8)) if_b ();
    control_unit_gen_if #(.OPW(8)) if_c ();

    assign if_a.opcode = opcode;  assign if_b.opcode = opcode;  assign if_c.opcode = opcode;
    assign if_a.zflg = zflg;      assign if_b.zflg = zflg;      assign if_c.zflg = zflg;
    assign if_a.nflg = nflg;      assign if_b.nflg = nflg;      assign if_c.nflg = nflg;
    assign if_a.mem_ready = mem_ready;
    assign if_b.mem_ready = mem_ready;
    assign if_c.mem_ready = mem_ready;
    assign if_a.irq = irq;        assign if_b.irq = irq;        assign if_c.irq = irq;

    control_unit_gen #(.OPW(8), .OPND_WORDS(1), .IRQ_EN(1'b1)) dut_a (
        .clk(clk), .reset(rst[0]), .bus(if_a));
    control_unit_gen #(.OPW(8), .OPND_WORDS(3), .IRQ_EN(1'b1)) dut_b (
        .clk(clk), .reset(rst[1]), .bus(if_b));
    control_unit_gen #(.OPW(8), .OPND_WORDS(1), .IRQ_EN(1'b0)) dut_c (
        .clk(clk), .reset(rst[2]), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            0: obs = {if_a.state_o, if_a.fetch, if_a.ld_iru, if_a.ld_opnd, if_a.opnd_idx,
                      if_a.incr_pc, if_a.mem_rd, if_a.ld_ac, if_a.ld_pc, if_a.store_mem,
                      if_a.irq_ack, if_a.halted};
            1: obs = {if_b.state_o, if_b.fetch, if_b.ld_iru, if_b.ld_opnd, if_b.opnd_idx,
                      if_b.incr_pc, if_b.mem_rd, if_b.ld_ac, if_b.ld_pc, if_b.store_mem,
                      if_b.irq_ack, if_b.halted};
            default: obs = {if_c.state_o, if_c.fetch, if_c.ld_iru, if_c.ld_opnd, if_c.opnd_idx,
                      if_c.incr_pc, if_c.mem_rd, if_c.ld_ac, if_c.ld_pc, if_c.store_mem,
                      if_c.irq_ack, if_c.halted};
        endcase
    end

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [7:0] r8();
        return 8'($urandom);
    endfunction

    function automatic logic [11:0] ix(int k);
        return 12'(k) << 7;
    endfunction

    task automatic push(input int st, input logic [11:0] str, input logic [7:0] op,
                        input logic mr, input logic z, input logic n, input logic iq);
        vec_t v;
        v.op = op; v.z = z; v.n = n; v.irq = iq; v.mr = mr;
        v.exp = {4'(st), str};
        q.push_back(v);
    endtask

    // Expands one instruction into expected cycles. wu/wl/wr/ws are the
    // number of mem_ready=0 cycles before each fetch/read/store completes.
    task automatic add_instr(input int nw, input bit ie, input logic [7:0] op,
                             input logic z, input logic n, input logic irqv,
                             input int wu, input int wl, input int wr, input int ws);
        bit cjump, taken, cls2, bnd_done;
        cjump = (op == 8'h11) || (op == 8'h12) || (op == 8'h13);
        taken = (op == 8'h10) || (op == 8'h11 && n) || (op == 8'h12 && !z) ||
                (op == 8'h13 && z);
        cls2  = (op == 8'h02) || (op == 8'h06) || (op == 8'h08) ||
                (op == 8'h0E) || (op == 8'h0F);
        bnd_done = 1'b0;
        push(1, F, r8(), rb(), rb(), rb(), rb());
        repeat (wu) push(2, F, r8(), 1'b0, rb(), rb(), rb());
        push(2, F | IRU | INC, r8(), 1'b1, rb(), rb(), rb());
        if (op == 8'h1F) begin
            push(3, F, op, rb(), rb(), rb(), rb());
            repeat (20) push(10, HLT, r8(), rb(), rb(), rb(), rb());
            return;
        end
        if (op == 8'h00 || op == 8'h04) begin
            push(3, F, op, rb(), rb(), rb(), rb());
            push(6, AC, op, rb(), rb(), rb(), irqv);
            bnd_done = 1'b1;
        end else begin
            for (int k = 0; k < nw; k++) begin
                push(3, F | ix(k), op, rb(), rb(), rb(), rb());
                repeat (wl) push(4, F | ix(k), op, 1'b0, rb(), rb(), rb());
                push(4, F | OPN | INC | ix(k), op, 1'b1, z, n,
                     (k == nw - 1 && cjump && !taken) ? irqv : rb());
            end
        end
        if (!bnd_done) begin
            if (cls2) begin
                push(6, AC, op, rb(), rb(), rb(), irqv);
            end else if (op == 8'h03) begin
                repeat (ws) push(7, ST, op, 1'b0, rb(), rb(), rb());
                push(7, ST, op, 1'b1, rb(), rb(), irqv);
            end else if (op == 8'h10 || cjump) begin
                if (taken) push(8, PC, op, rb(), rb(), rb(), irqv);
            end else begin
                repeat (wr) push(5, RD, op, 1'b0, rb(), rb(), rb());
                push(5, RD, op, 1'b1, rb(), rb(), rb());
                push(6, AC, op, rb(), rb(), rb(), irqv);
            end
        end
        if (ie && irqv) push(9, ACK | PC, r8(), rb(), rb(), rb(), rb());
    endtask

    task automatic add_random(input int nw, input bit ie, input int count);
        logic [7:0] ops [16] = '{8'h00, 8'h04, 8'h02, 8'h06, 8'h08, 8'h0E, 8'h0F, 8'h03,
                                 8'h10, 8'h11, 8'h12, 8'h13, 8'h05, 8'h01, 8'h07, 8'h25};
        for (int i = 0; i < count; i++)
            add_instr(nw, ie, ops[$urandom_range(0, 15)], rb(), rb(), rb(),
                      $urandom_range(0, 2), $urandom_range(0, 2),
                      $urandom_range(0, 2), $urandom_range(0, 2));
    endtask

    task automatic check(input string tag, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, sel, obs, exp);
        end
    endtask

    task automatic drive_random();
        opcode = r8(); zflg = rb(); nflg = rb(); irq = rb(); mem_ready = rb();
    endtask

    // Called at posedge+1 with every instance in reset; checks the reset
    // outputs, releases instance s and plays the expected-cycle queue.
    task automatic play(input int s);
        vec_t v;
        sel = s;
        drive_random();
        @(negedge clk);
        check("reset", 16'h0000);
        @(posedge clk); #1;
        rst[s] = 1'b0;
        while (q.size() > 0) begin
            v = q.pop_front();
            opcode = v.op; zflg = v.z; nflg = v.n; irq = v.irq; mem_ready = v.mr;
            @(negedge clk);
            check("trace", v.exp);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        sel = 0;
        rst = 3'b111;
        drive_random();
        @(posedge clk); #1;

        // One operand word, interrupts enabled.
        q.delete();
        push(0, 12'h000, r8(), rb(), rb(), rb(), rb());
        add_instr(1, 1'b1, 8'h02, 0, 0, 0, 0, 0, 0, 0);
        add_instr(1, 1'b1, 8'h05, 0, 0, 0, 0, 0, 3, 0);
        add_instr(1, 1'b1, 8'h13, 0, 0, 0, 1, 1, 0, 0);
        add_instr(1, 1'b1, 8'h13, 1, 0, 0, 0, 0, 0, 0);
        add_instr(1, 1'b1, 8'h12, 0, 1, 0, 0, 0, 0, 0);
        add_instr(1, 1'b1, 8'h06, 0, 0, 1, 0, 0, 0, 0);
        add_instr(1, 1'b1, 8'h11, 0, 0, 1, 0, 0, 0, 0);
        add_random(1, 1'b1, 30);
        add_instr(1, 1'b1, 8'h1F, 0, 0, 0, 1, 0, 0, 0);
        play(0);
        rst[0] = 1'b1;

        // Three operand words.
        q.delete();
        push(0, 12'h000, r8(), rb(), rb(), rb(), rb());
        add_instr(3, 1'b1, 8'h03, 0, 0, 0, 0, 0, 0, 2);
        add_random(3, 1'b1, 15);
        add_instr(3, 1'b1, 8'h1F, 0, 0, 0, 0, 0, 0, 0);
        play(1);
        rst[1] = 1'b1;

        // Interrupt path disabled.
        q.delete();
        push(0, 12'h000, r8(), rb(), rb(), rb(), rb());
        add_instr(1, 1'b0, 8'h06, 0, 0, 1, 0, 0, 0, 0);
        add_instr(1, 1'b0, 8'h13, 0, 0, 1, 0, 0, 0, 0);
        add_random(1, 1'b0, 15);
        add_instr(1, 1'b0, 8'h1F, 0, 0, 0, 0, 0, 0, 0);
        play(2);
        rst[2] = 1'b1;

        // Asynchronous reset in the middle of a stalled FETCHL.
        q.delete();
        push(0, 12'h000, r8(), rb(), rb(), rb(), rb());
        push(1, F, r8(), rb(), rb(), rb(), rb());
        push(2, F | IRU | INC, r8(), 1'b1, rb(), rb(), rb());
        push(3, F, 8'h05, rb(), rb(), rb(), rb());
        push(4, F, 8'h05, 1'b0, rb(), rb(), rb());
        play(0);
        mem_ready = 1'b1;
        #1;
        check("fetchl_ready", {4'd4, F | OPN | INC});
        rst[0] = 1'b1;
        #1;
        check("async_reset", 16'h0000);
        @(negedge clk);
        check("reset_hold", 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
